// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light lamp monitor: phase encoding,
// default dwell bounds and the legal phase-transition rule.
package tl_pkg;

  localparam logic [2:0] P_R1G = 3'd0;
  localparam logic [2:0] P_R1Y = 3'd1;
  localparam logic [2:0] P_R2G = 3'd2;
  localparam logic [2:0] P_R2Y = 3'd3;
  localparam logic [2:0] P_FG  = 3'd4;
  localparam logic [2:0] P_FY  = 3'd5;
  localparam logic [2:0] P_BAD = 3'd7;

  localparam int unsigned Y_MIN_DEF = 3;
  localparam int unsigned Y_MAX_DEF = 3;
  localparam int unsigned G_MAX_DEF = 15;
  localparam int unsigned CW_DEF    = 5;

  // c is the sensor value seen in the last cycle of the phase being left.
  function automatic logic legal_trans(input logic [2:0] prev, input logic [2:0] next,
                                       input logic c);
    logic ok;
    ok = 1'b0;
    case (prev)
      P_R1G:   ok = (next == P_R1Y);
      P_R1Y:   ok = c ? (next == P_FG) : (next == P_R2G);
      P_R2G:   ok = (next == P_R2Y);
      P_R2Y:   ok = c ? (next == P_FG) : (next == P_R1G);
      P_FG:    ok = (next == P_FY);
      P_FY:    ok = (next == P_R1G);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_yellow(input logic [2:0] p);
    return (p == P_R1Y) || (p == P_R2Y) || (p == P_FY);
  endfunction

  function automatic logic is_green(input logic [2:0] p);
    return (p == P_R1G) || (p == P_R2G) || (p == P_FG);
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Combinational nine-lamp decoder: maps the lamp pattern to a phase code and
// flags malformed roads (not one-hot) and conflicting go-signals.
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic       R1G,
  input  logic       R1Y,
  input  logic       R1R,
  input  logic       R2G,
  input  logic       R2Y,
  input  logic       R2R,
  input  logic       FG,
  input  logic       FY,
  input  logic       FR,
  output logic [2:0] phase,
  output logic       onehot_bad,
  output logic       conflict
);

  logic [2:0] non_red;

  // Decode the single non-red lamp; anything ambiguous or all-red is BAD.
  always_comb begin
    non_red    = {~R1R, ~R2R, ~FR};
    onehot_bad = !($onehot({R1G, R1Y, R1R}) && $onehot({R2G, R2Y, R2R}) &&
                   $onehot({FG, FY, FR}));
    conflict   = !$onehot0(non_red);
    phase      = P_BAD;
    if (!onehot_bad && !conflict) begin
      if (!R1R)      phase = R1Y ? P_R1Y : P_R1G;
      else if (!R2R) phase = R2Y ? P_R2Y : P_R2G;
      else if (!FR)  phase = FY ? P_FY : P_FG;
    end
  end

endmodule

// File: rtl/tl_lamp_monitor.sv
// Passive checker for the traffic-light lamp interface. Registers the decoded
// phase and its dwell, and raises sticky flags for safety, sequencing and
// timing violations. Optional statistics counters: TL_MON_STATS_EN.
module tl_lamp_monitor
  import tl_pkg::*;
#(
  parameter int unsigned Y_MIN = Y_MIN_DEF,
  parameter int unsigned Y_MAX = Y_MAX_DEF,
  parameter int unsigned G_MAX = G_MAX_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          R1G,
  input  logic          R1Y,
  input  logic          R1R,
  input  logic          R2G,
  input  logic          R2Y,
  input  logic          R2R,
  input  logic          FG,
  input  logic          FY,
  input  logic          FR,
  input  logic          c,
  input  logic          clr,
  output logic [2:0]    phase,
  output logic [CW-1:0] dwell,
  output logic          err_onehot,
  output logic          err_conflict,
  output logic          err_seq,
  output logic          err_timing,
  output logic          err_any
`ifdef TL_MON_STATS_EN
  ,
  output logic [7:0]    farm_serv,
  output logic [7:0]    rounds
`endif
);

  localparam logic [CW-1:0] DwellOne = CW'(1);
  localparam logic [CW-1:0] DwellMax = {CW{1'b1}};
  localparam logic [CW-1:0] YMinW    = CW'(Y_MIN);
  localparam logic [CW-1:0] YMaxW    = CW'(Y_MAX);
  localparam logic [CW-1:0] GMaxW    = CW'(G_MAX);

  logic [2:0]    dec_phase;
  logic          oh_bad, conflict;
  // phase_q also serves as the previous phase for transition checks.
  logic [2:0]    phase_q;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          first_q, c_q;
  logic          oh_q, cf_q, seq_q, tim_q;
  logic          v_seq, v_tim, legal_entry;

  tl_phase_decode u_decode (
    .R1G        (R1G),
    .R1Y        (R1Y),
    .R1R        (R1R),
    .R2G        (R2G),
    .R2Y        (R2Y),
    .R2R        (R2R),
    .FG         (FG),
    .FY         (FY),
    .FR         (FR),
    .phase      (dec_phase),
    .onehot_bad (oh_bad),
    .conflict   (conflict)
  );

  // Next dwell value plus sequencing and timing violations for this sample.
  always_comb begin
    dwell_d     = dwell_q;
    legal_entry = 1'b0;
    v_tim       = 1'b0;
    // All-red decodes to BAD without a lamp-level fault.
    v_seq       = (dec_phase == P_BAD) && !oh_bad && !conflict;
    if (first_q) begin
      dwell_d = DwellOne;
      if (dec_phase != P_R1G) v_seq = 1'b1;
    end else if (dec_phase != phase_q) begin
      dwell_d = DwellOne;
      if (phase_q != P_BAD && dec_phase != P_BAD) begin
        if (legal_trans(phase_q, dec_phase, c_q)) legal_entry = 1'b1;
        else                                     v_seq       = 1'b1;
      end
      if (is_yellow(phase_q) && dwell_q < YMinW) v_tim = 1'b1;
    end else begin
      if (dwell_q != DwellMax) dwell_d = dwell_q + DwellOne;
      if (is_yellow(phase_q) && dwell_d > YMaxW) v_tim = 1'b1;
      if (is_green(phase_q) && dwell_d > GMaxW)  v_tim = 1'b1;
    end
  end

  // Phase/dwell tracking and sticky flags; a new violation beats clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= P_R1G;
      dwell_q <= '0;
      first_q <= 1'b1;
      c_q     <= 1'b0;
      oh_q    <= 1'b0;
      cf_q    <= 1'b0;
      seq_q   <= 1'b0;
      tim_q   <= 1'b0;
    end else begin
      phase_q <= dec_phase;
      dwell_q <= dwell_d;
      first_q <= 1'b0;
      c_q     <= c;
      oh_q    <= (oh_q  & ~clr) | oh_bad;
      cf_q    <= (cf_q  & ~clr) | conflict;
      seq_q   <= (seq_q & ~clr) | v_seq;
      tim_q   <= (tim_q & ~clr) | v_tim;
    end
  end

  assign phase        = phase_q;
  assign dwell        = dwell_q;
  assign err_onehot   = oh_q;
  assign err_conflict = cf_q;
  assign err_seq      = seq_q;
  assign err_timing   = tim_q;
  assign err_any      = oh_q | cf_q | seq_q | tim_q;

`ifdef TL_MON_STATS_EN
  logic [7:0] farm_q, rounds_q;

  // Count legal entries into FG and R1G (the first R1G is not a transition).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      farm_q   <= '0;
      rounds_q <= '0;
    end else if (legal_entry) begin
      if (dec_phase == P_FG)  farm_q   <= farm_q + 8'd1;
      if (dec_phase == P_R1G) rounds_q <= rounds_q + 8'd1;
    end
  end

  assign farm_serv = farm_q;
  assign rounds    = rounds_q;
`endif

endmodule

// File: tb/tb_tl_lamp_monitor.sv
// Directed bench for tl_lamp_monitor with a phase-level reference model.
module tb_tl_lamp_monitor;

  localparam logic [8:0] L_R1G   = 9'b100_001_001;
  localparam logic [8:0] L_R1Y   = 9'b010_001_001;
  localparam logic [8:0] L_R2G   = 9'b001_100_001;
  localparam logic [8:0] L_R2Y   = 9'b001_010_001;
  localparam logic [8:0] L_FG    = 9'b001_001_100;
  localparam logic [8:0] L_FY    = 9'b001_001_010;
  localparam logic [8:0] L_ALLRD = 9'b001_001_001;
  localparam logic [8:0] L_CONF  = 9'b100_001_100;
  localparam logic [8:0] L_OHBAD = 9'b101_001_001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR;
  logic c = 1'b0;
  logic clr = 1'b0;
  logic [2:0] phase;
  logic [4:0] dwell;
  logic err_onehot, err_conflict, err_seq, err_timing, err_any;
`ifdef TL_MON_STATS_EN
  logic [7:0] farm_serv, rounds;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase, m_dwell, m_farm, m_rounds;
  bit m_first, m_cprev, m_oh, m_cf, m_sq, m_tm;

  tl_lamp_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .R1G          (R1G),
    .R1Y          (R1Y),
    .R1R          (R1R),
    .R2G          (R2G),
    .R2Y          (R2Y),
    .R2R          (R2R),
    .FG           (FG),
    .FY           (FY),
    .FR           (FR),
    .c            (c),
    .clr          (clr),
    .phase        (phase),
    .dwell        (dwell),
    .err_onehot   (err_onehot),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_timing   (err_timing),
    .err_any      (err_any)
`ifdef TL_MON_STATS_EN
    ,
    .farm_serv    (farm_serv),
    .rounds       (rounds)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single legal successor of each phase given the sensor seen while leaving it.
  function automatic int succ(input int p, input bit cc);
    case (p)
      0: return 1;
      1: return cc ? 4 : 2;
      2: return 3;
      3: return cc ? 4 : 0;
      4: return 5;
      5: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_first = 1; m_cprev = 0;
    m_oh = 0; m_cf = 0; m_sq = 0; m_tm = 0; m_farm = 0; m_rounds = 0;
  endtask

  task automatic model_update();
    logic [8:0] lv;
    int nonred, dec, road_y;
    bit bad_oh, v_sq, v_tm;
    lv = {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR};
    bad_oh = 0; nonred = 0; dec = 7; road_y = 0; v_sq = 0; v_tm = 0;
    for (int r = 0; r < 3; r++) begin
      int g, y, rd;
      g  = int'(lv[8 - 3*r]);
      y  = int'(lv[7 - 3*r]);
      rd = int'(lv[6 - 3*r]);
      if (g + y + rd != 1) bad_oh = 1;
      if (rd == 0) begin
        nonred++;
        dec = 2*r + y;
      end
    end
    if (bad_oh || nonred > 1) dec = 7;
    else if (nonred == 0) begin
      dec = 7;
      v_sq = 1;
    end
    if (m_first) begin
      if (dec != 0) v_sq = 1;
      m_dwell = 1;
    end else if (dec != m_phase) begin
      if (m_phase != 7 && dec != 7) begin
        if (dec != succ(m_phase, m_cprev)) v_sq = 1;
        else if (dec == 4) m_farm = (m_farm + 1) % 256;
        else if (dec == 0) m_rounds = (m_rounds + 1) % 256;
      end
      if ((m_phase % 2 == 1) && m_phase != 7 && m_dwell < 3) v_tm = 1;
      m_dwell = 1;
    end else begin
      if (m_dwell < 31) m_dwell++;
      if ((m_phase % 2 == 1) && m_phase != 7 && m_dwell > 3) v_tm = 1;
      if ((m_phase % 2 == 0) && m_phase < 6 && m_dwell > 15) v_tm = 1;
    end
    m_oh = (m_oh && !clr) || bad_oh;
    m_cf = (m_cf && !clr) || (nonred > 1);
    m_sq = (m_sq && !clr) || v_sq;
    m_tm = (m_tm && !clr) || v_tm;
    m_phase = dec; m_first = 0; m_cprev = c;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    check("phase", int'(phase), m_phase);
    check("dwell", int'(dwell), m_dwell);
    check("err_onehot", int'(err_onehot), int'(m_oh));
    check("err_conflict", int'(err_conflict), int'(m_cf));
    check("err_seq", int'(err_seq), int'(m_sq));
    check("err_timing", int'(err_timing), int'(m_tm));
    check("err_any", int'(err_any), int'(m_oh | m_cf | m_sq | m_tm));
`ifdef TL_MON_STATS_EN
    check("farm_serv", int'(farm_serv), m_farm);
    check("rounds", int'(rounds), m_rounds);
`endif
  endtask

  task automatic step(input logic [8:0] l, input logic cc, input logic cl);
    {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR} = l;
    c = cc;
    clr = cl;
    @(posedge clk);
    #1 model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [8:0] l, input logic cc, input int n);
    for (int i = 0; i < n; i++) step(l, cc, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    clr = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR} = L_R1G;
    model_reset();
    do_reset(2);
    check("lit_reset_phase", int'(phase), 0);
    check("lit_reset_dwell", int'(dwell), 0);
    check("lit_reset_any", int'(err_any), 0);

    // Normal round, c=0
    hold(L_R1G, 0, 1);
    check("lit_first_dwell", int'(dwell), 1);
    hold(L_R1G, 0, 9); hold(L_R1Y, 0, 3); hold(L_R2G, 0, 10); hold(L_R2Y, 0, 3);
    hold(L_R1G, 0, 2);
    check("lit_round_phase", int'(phase), 0);
    check("lit_round_dwell", int'(dwell), 2);
    check("lit_round_any", int'(err_any), 0);

    // Farm service
    do_reset(2);
    hold(L_R1G, 0, 5); hold(L_R1Y, 1, 3); hold(L_FG, 1, 1);
    check("lit_farm_fg", int'(phase), 4);
    hold(L_FG, 1, 5); hold(L_FY, 0, 1);
    check("lit_farm_fy", int'(phase), 5);
    hold(L_FY, 0, 2); hold(L_R1G, 0, 2);
    check("lit_farm_r1g", int'(phase), 0);
    check("lit_farm_any", int'(err_any), 0);
`ifdef TL_MON_STATS_EN
    check("lit_farm_serv", int'(farm_serv), 1);
    check("lit_rounds", int'(rounds), 1);
`endif

    // Conflict, sticky across a clean stretch, then clear
    step(L_CONF, 0, 0);
    check("lit_conflict", int'(err_conflict), 1);
    check("lit_conflict_any", int'(err_any), 1);
    hold(L_R1G, 0, 10); hold(L_R1Y, 0, 3); hold(L_R2G, 0, 7);
    check("lit_conflict_sticky", int'(err_conflict), 1);
    step(L_R2G, 0, 1);
    check("lit_conflict_clr", int'(err_conflict), 0);
    check("lit_clr_any", int'(err_any), 0);

    // Short yellow
    do_reset(1);
    hold(L_R1G, 0, 3); hold(L_R1Y, 0, 2); hold(L_R2G, 0, 2);
    check("lit_short_yellow", int'(err_timing), 1);
    check("lit_short_yellow_seq", int'(err_seq), 0);

    // Long green: flag rises on the cycle dwell reaches 16
    do_reset(1);
    hold(L_R1G, 0, 3); hold(L_R1Y, 0, 3); hold(L_R2G, 0, 15);
    check("lit_green15_tim", int'(err_timing), 0);
    hold(L_R2G, 0, 1);
    check("lit_green16_dwell", int'(dwell), 16);
    check("lit_green16_tim", int'(err_timing), 1);

    // Long yellow
    do_reset(1);
    hold(L_R1G, 0, 2); hold(L_R1Y, 0, 3);
    check("lit_yellow3_tim", int'(err_timing), 0);
    hold(L_R1Y, 0, 1);
    check("lit_yellow4_tim", int'(err_timing), 1);

    // First phase not R1G
    do_reset(1);
    hold(L_R2G, 0, 2);
    check("lit_first_r2g_seq", int'(err_seq), 1);
    check("lit_first_r2g_phase", int'(phase), 2);

    // R1Y -> R2G while c=1, then clr coinciding with an all-red violation
    do_reset(1);
    hold(L_R1G, 0, 2); hold(L_R1Y, 1, 3); hold(L_R2G, 0, 2);
    check("lit_bad_branch_seq", int'(err_seq), 1);
    check("lit_bad_branch_tim", int'(err_timing), 0);
    step(L_ALLRD, 0, 1);
    check("lit_clr_vs_viol", int'(err_seq), 1);
    check("lit_allred_phase", int'(phase), 7);
    step(L_R1G, 0, 1);
    check("lit_leave_bad_clr", int'(err_seq), 0);

    // Reset mid-FG
    do_reset(1);
    hold(L_R1G, 0, 3); hold(L_R1Y, 1, 3); hold(L_FG, 1, 3);
    do_reset(2);
    hold(L_R1G, 0, 1);
    check("lit_rst_mid_phase", int'(phase), 0);
    check("lit_rst_mid_dwell", int'(dwell), 1);
    check("lit_rst_mid_any", int'(err_any), 0);
`ifdef TL_MON_STATS_EN
    check("lit_rst_mid_farm", int'(farm_serv), 0);
`endif
    hold(L_R1G, 0, 2);

    // Malformed road and dwell saturation
    do_reset(1);
    hold(L_OHBAD, 0, 1);
    check("lit_onehot", int'(err_onehot), 1);
    check("lit_onehot_phase", int'(phase), 7);
    hold(L_OHBAD, 0, 39);
    check("lit_dwell_sat", int'(dwell), 31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_lamp_monitor.md
Name: tl_lamp_monitor

Overview:
- Passive checker on the receiving end of the traffic-light controller's lamp interface. It samples the nine lamp lines plus the farm-road sensor `c`.
- Decodes the current phase and checks safety (one lamp per road, no conflicting go-signals), phase sequencing and phase dwell times. Violations are reported as sticky error flags.
- Sits beside the controller in the top level and in the bench; it drives nothing back into the controller.

Parameters:
- Y_MIN, 3, minimum cycles any yellow phase must last
- Y_MAX, 3, maximum cycles any yellow phase may last
- G_MAX, 15, maximum cycles any green phase may last
- CW, 5, dwell counter width; must satisfy 2^CW-1 > max(G_MAX, Y_MAX)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- R1G, R1Y, R1R  in  1 each  road 1 green/yellow/red lamps
- R2G, R2Y, R2R  in  1 each  road 2 lamps
- FG, FY, FR  in  1 each  farm-road lamps
- c  in  1  farm-road car sensor, same signal the controller uses
- clr  in  1  synchronous clear of sticky error flags
- phase  out  3  decoded registered phase: 0 R1G, 1 R1Y, 2 R2G, 3 R2Y, 4 FG, 5 FY, 7 BAD
- dwell  out  CW  cycles spent in the current phase, saturating
- err_onehot  out  1  a road showed zero or more than one lit lamp
- err_conflict  out  1  more than one road was non-red
- err_seq  out  1  illegal phase transition
- err_timing  out  1  dwell bound violated
- err_any  out  1  OR of the four flags

Behaviour:
- Reset (async, rst_n=0):
  - phase=0, dwell=0, all error flags 0.
  - Internal prev_phase=0; first_flag=1.
- Decode (combinational, every cycle):
  - Each road must be one-hot across G/Y/R; otherwise the phase is BAD and err_onehot sets.
  - More than one road non-red sets err_conflict.
  - Otherwise phase = the single non-red lamp. All three roads red is BAD, and err_seq sets.
- Registering: all outputs update on the clock edge after the sample, so latency is 1 cycle from lamp change to phase/flag.
- Legal transitions (the phase register changes only when the decoded phase differs):
  - R1G→R1Y
  - R1Y→R2G only if c was 0 in the last cycle of R1Y
  - R1Y→FG only if c was 1 in the last cycle of R1Y
  - R2G→R2Y
  - R2Y→R1G (c=0) or R2Y→FG (c=1)
  - FG→FY, any time
  - FY→R1G
  - Any other change sets err_seq. Leaving BAD resumes tracking and flags nothing further for that change.
- First phase after reset:
  - First decoded phase must be R1G; anything else sets err_seq.
  - first_flag clears after the first sample.
- Dwell counter:
  - Counts 1 on the first cycle of a phase and increments each cycle, saturating at 2^CW-1.
  - On a phase change it reloads to 1.
- Timing checks:
  - Leaving a yellow with dwell < Y_MIN, or yellow dwell reaching Y_MAX+1, sets err_timing.
  - Green dwell reaching G_MAX+1 sets err_timing.
  - There is no green minimum, because FG legitimately ends early when c drops.
- Sticky flags:
  - Each flag stays set until rst_n=0 or clr=1.
  - If clr and a new violation coincide, the violation wins (flag stays 1).
- Reset mid-operation: everything returns to reset values, and the R1G expectation is re-armed.

Optional Feature:
- TL_MON_STATS_EN defined:
  - Adds outputs farm_serv (8 bit) and rounds (8 bit), both wrapping counters, reset 0.
  - farm_serv increments on each legal entry into FG.
  - rounds increments on each legal entry into R1G, excluding the first entry after reset.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package tl_pkg holds:
  - phase encoding localparams P_R1G..P_FY, P_BAD
  - the legal-transition function taking (prev, next, c)
  - the default dwell constants
- One sub-module, tl_phase_decode: the combinational nine-lamp decoder producing phase, onehot_bad and conflict. The sequential checker stays in the top module.

Test Plan:
- Normal round with c=0: R1G 10 cycles, R1Y 3, R2G 10, R2Y 3, back to R1G → phase sequence 0,1,2,3,0; all flags 0.
- Farm service: c=1 during R1Y, then FG 6 cycles, FY 3, R1G → phase 4 then 5 then 0; no flags. With the macro defined, farm_serv=1 and rounds=1.
- Conflict: drive R1G=1 and FG=1 (R1R=0, FR=0) for 1 cycle → err_conflict=1 one cycle later; err_any=1; still 1 after 20 clean cycles; clr=1 → 0.
- Timing: R1Y held 2 cycles then R2G → err_timing=1. Separately, R2G held 16 cycles → err_timing=1 on the cycle dwell hits 16.
- Sequence: after reset the first phase is R2G → err_seq=1. Separately, R1Y→R2G while c=1 → err_seq=1.
- Reset mid-FG: assert rst_n=0 for 2 cycles, release into R1G → all outputs 0, phase=0, dwell counts from 1, no flags.
